// File: rtl/centimos_euros_seq.sv
// ---------------------------------------------------------------------------
// centimos_euros_seq
// Converts an unsigned amount in cents into whole euros plus remaining cents.
// The input can optionally be rounded to the nearest 5 cents first. The
// division by 100 is a bit-serial restoring divider producing one quotient
// bit per clock (W+1 cycles).
//
// Ports
//   clk           : clock, rising edge
//   rst_n         : asynchronous active-low reset
//   centimos      : amount in cents (W bits)
//   round5        : 1 = round to nearest 5 cents before conversion
//   in_valid      : request valid
//   in_ready      : block idle, request will be accepted
//   eurosinteiros : whole euros (W bits)
//   eurosfracao   : remaining cents 0..99
//   out_valid     : result valid, held until out_ready
//   out_ready     : consumer accepts result
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// CALC  | shifting dividend through the restoring divider
// DONE  | result presented, waiting for out_ready
// ---------------------------------------------------------------------------
module centimos_euros_seq #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] centimos,
  input  logic         round5,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] eurosinteiros,
  output logic [6:0]   eurosfracao,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CW-1:0] cnt;
  logic [W:0]    dvd;
  logic [6:0]    rem;

  logic [15:0] cent_ext;
  logic [5:0]  nib_sum;
  logic [4:0]  fold_sum;
  logic [2:0]  mod5;
  logic [W:0]  dvd_in;

  logic [7:0] trial;
  logic       ge;
  logic [6:0] rem_next;

  // centimos mod 5 without a wide modulo: 16 = 1 (mod 5), so the sum of the
  // hex digits has the same residue. Folding twice leaves a value <= 18.
  always_comb begin
    cent_ext = 16'(centimos);
    nib_sum  = 6'(cent_ext[3:0]) + 6'(cent_ext[7:4]) +
               6'(cent_ext[11:8]) + 6'(cent_ext[15:12]);
    fold_sum = 5'(nib_sum[5:4]) + 5'(nib_sum[3:0]);
    if (fold_sum >= 5'd15)      mod5 = 3'(fold_sum - 5'd15);
    else if (fold_sum >= 5'd10) mod5 = 3'(fold_sum - 5'd10);
    else if (fold_sum >= 5'd5)  mod5 = 3'(fold_sum - 5'd5);
    else                        mod5 = 3'(fold_sum);

    dvd_in = {1'b0, centimos};
    if (round5) begin
      if (mod5 <= 3'd2) dvd_in = {1'b0, centimos} - (W+1)'(mod5);
      else              dvd_in = {1'b0, centimos} + (W+1)'(3'd5 - mod5);
    end
  end

  // One restoring step: trial remainder is always < 200, so the subtracted
  // result fits in 7 bits and can be computed modulo 128.
  always_comb begin
    trial    = {rem, dvd[W]};
    ge       = (trial >= 8'd100);
    rem_next = ge ? (trial[6:0] - 7'd100) : trial[6:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = CALC;
      CALC:    if (cnt == CW'(0)) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // The dividend register doubles as the quotient register: quotient bits
  // shift in at the bottom as dividend bits leave at the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      dvd           <= '0;
      rem           <= '0;
      eurosinteiros <= '0;
      eurosfracao   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd <= dvd_in;
            rem <= '0;
            cnt <= CW'(W);
          end
        end
        CALC: begin
          dvd <= {dvd[W-1:0], ge};
          rem <= rem_next;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(0)) begin
            eurosinteiros <= {dvd[W-2:0], ge};
            eurosfracao   <= rem_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_centimos_euros_seq.sv
module tb_centimos_euros_seq;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] centimos;
  logic         round5;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] eurosinteiros;
  logic [6:0]   eurosfracao;
  logic         out_valid;
  logic         out_ready;

  int checks = 0;
  int errors = 0;

  centimos_euros_seq #(.W(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .centimos      (centimos),
    .round5        (round5),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .eurosinteiros (eurosinteiros),
    .eurosfracao   (eurosfracao),
    .out_valid     (out_valid),
    .out_ready     (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int c;
    bit r5;
    int q;
    int f;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: round to nearest 5 (ties cannot occur), then plain / and %.
  function automatic void model(input int c, input bit r5, output int q, output int f);
    int d;
    d = c;
    if (r5) begin
      if (c % 5 <= 2) d = c - (c % 5);
      else            d = c + 5 - (c % 5);
    end
    q = d / 100;
    f = d % 100;
  endfunction

  task automatic run_req(input int c, input bit r5, input int stall, input bit noisy,
                         input bit or_noise, input string name);
    int q, f, lat;
    model(c, r5, q, f);
    @(negedge clk);
    centimos  = W'(c);
    round5    = r5;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    chk({name, "/in_ready_idle"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    centimos = W'($urandom);
    round5   = 1'($urandom);
    lat = 0;
    do begin
      if (or_noise) out_ready = 1'($urandom);
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 50);
    out_ready = 1'b0;
    chk({name, "/latency"}, 32'(lat), 32'(W + 1));
    chk({name, "/euros"}, 32'(eurosinteiros), 32'(q));
    chk({name, "/cents"}, 32'(eurosfracao), 32'(f));
    for (int s = 0; s < stall; s++) begin
      if (noisy) begin
        in_valid = 1'b1;
        centimos = ~centimos;
        round5   = ~round5;
      end
      @(posedge clk);
      #1;
      chk({name, "/hold_valid"}, 32'(out_valid), 32'd1);
      chk({name, "/hold_ready"}, 32'(in_ready), 32'd0);
      chk({name, "/hold_euros"}, 32'(eurosinteiros), 32'(q));
      chk({name, "/hold_cents"}, 32'(eurosfracao), 32'(f));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({name, "/ret_idle"}, 32'(in_ready), 32'd1);
    chk({name, "/ret_valid"}, 32'(out_valid), 32'd0);
    chk({name, "/keep_euros"}, 32'(eurosinteiros), 32'(q));
    chk({name, "/keep_cents"}, 32'(eurosfracao), 32'(f));
  endtask

  initial begin
    int off, idx;
    vecs[0] = '{470, 1'b0, 4, 70};
    vecs[1] = '{473, 1'b1, 4, 75};
    vecs[2] = '{472, 1'b1, 4, 70};
    vecs[3] = '{1023, 1'b1, 10, 25};
    vecs[4] = '{0, 1'b0, 0, 0};
    vecs[5] = '{99, 1'b0, 0, 99};
    vecs[6] = '{100, 1'b0, 1, 0};
    vecs[7] = '{1023, 1'b0, 10, 23};

    rst_n     = 1'b0;
    centimos  = '0;
    round5    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #3;
    chk("reset/in_ready", 32'(in_ready), 32'd1);
    chk("reset/out_valid", 32'(out_valid), 32'd0);
    chk("reset/euros", 32'(eurosinteiros), 32'd0);
    chk("reset/cents", 32'(eurosfracao), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors: expected values are written out by hand.
    for (int i = 0; i < 8; i++) begin
      int q, f;
      model(vecs[i].c, vecs[i].r5, q, f);
      chk($sformatf("vec%0d/model", i), 32'(q * 100 + f), 32'(vecs[i].q * 100 + vecs[i].f));
      run_req(vecs[i].c, vecs[i].r5, 0, 1'b0, 1'b0, $sformatf("vec%0d", i));
    end

    // Backpressure: 5 stall cycles with a new request pending and inputs toggling.
    run_req(470, 1'b0, 5, 1'b1, 1'b0, "backpressure");
    chk("bp/no_accept_euros", 32'(eurosinteiros), 32'd4);

    // Reset in the middle of CALC; outputs currently hold 4/70.
    @(negedge clk);
    centimos = W'(470);
    round5   = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset/in_ready", 32'(in_ready), 32'd1);
    chk("midreset/out_valid", 32'(out_valid), 32'd0);
    chk("midreset/euros", 32'(eurosinteiros), 32'd0);
    chk("midreset/cents", 32'(eurosfracao), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("midreset/no_partial", 32'(out_valid), 32'd0);
    run_req(250, 1'b0, 0, 1'b0, 1'b0, "after_reset");

    // Full sweep of 1024 values x round5 in a random permutation, with random
    // out_ready during CALC and random DONE stalls.
    off = $urandom_range(0, 2047);
    for (int i = 0; i < 2048; i++) begin
      idx = (i * 1237 + off) % 2048;
      run_req(idx >> 1, 1'(idx & 1), $urandom_range(0, 3), 1'($urandom), 1'b1,
              $sformatf("sweep c=%0d r5=%0d", idx >> 1, idx & 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
